// File: rtl/fft_stream_seq_if.sv
// Signal bundle for fft_stream_seq: sample input stream, FFT core load/start/readout
// port, and bin output stream. The master modport is the sequencer side.
interface fft_stream_seq_if #(
    parameter int BIT_WIDTH = 16,
    parameter int N         = 9
);
    logic                          s_valid;
    logic                          s_ready;
    logic signed [BIT_WIDTH-1:0]   s_data;
    logic                          fft_load;
    logic                          fft_start;
    logic [N-1:0]                  add_rd;
    logic [2*BIT_WIDTH-1:0]        din;
    logic signed [2*BIT_WIDTH-1:0] dout;
    logic                          fft_done;
    logic                          m_valid;
    logic                          m_ready;
    logic [2*BIT_WIDTH-1:0]        m_data;
    logic [N-1:0]                  m_index;
    logic                          m_last;
    logic                          busy;

    modport master (
        input  s_valid, s_data, dout, fft_done, m_ready,
        output s_ready, fft_load, fft_start, add_rd, din,
               m_valid, m_data, m_index, m_last, busy
    );

    modport slave (
        output s_valid, s_data, dout, fft_done, m_ready,
        input  s_ready, fft_load, fft_start, add_rd, din,
               m_valid, m_data, m_index, m_last, busy
    );
endinterface

// File: rtl/fft_stream_seq.sv
// Sequencer around the radix-2 FFT core: load a frame, start, wait for done, stream bins out.
// Define FFT_SEQ_BITREV_EN to write samples at bit-reversed load addresses.
module fft_stream_seq #(
    parameter int BIT_WIDTH = 16,
    parameter int N         = 9
) (
    input logic              clk,
    input logic              reset,
    fft_stream_seq_if.master bus
);
    localparam logic [N-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {S_LOAD, S_START, S_WAIT, S_READ} state_e;

    state_e                 state_q, state_d;
    logic [N-1:0]           k_q;
    logic                   s_ready_q;
    logic                   fft_load_q;
    logic                   fft_start_q;
    logic [N-1:0]           load_addr_q;
    logic [2*BIT_WIDTH-1:0] din_q;
    logic [N:0]             rd_ptr_q;
    logic                   ret_q;
    logic [N-1:0]           ret_idx_q;
    logic [2*BIT_WIDTH-1:0] fifo_data_q [2];
    logic [N-1:0]           fifo_idx_q  [2];
    logic                   fifo_wp_q, fifo_rp_q;
    logic [1:0]             fifo_cnt_q;

    logic accept, issue, push, pop, m_valid, last_pop;

    function automatic logic [N-1:0] load_addr(input logic [N-1:0] k);
        logic [N-1:0] a;
`ifdef FFT_SEQ_BITREV_EN
        for (int i = 0; i < N; i++) a[i] = k[N-1-i];
`else
        a = k;
`endif
        return a;
    endfunction

    assign accept   = (state_q == S_LOAD) && s_ready_q && bus.s_valid;
    assign m_valid  = (fifo_cnt_q != 2'd0);
    assign pop      = m_valid && bus.m_ready;
    assign last_pop = pop && (fifo_idx_q[fifo_rp_q] == LAST_IDX);
    assign push     = ret_q;
    // A read issued now lands in the FIFO next cycle, so count the one still in flight.
    assign issue    = (state_q == S_READ) && !rd_ptr_q[N] &&
                      (({1'b0, fifo_cnt_q} + {2'b00, ret_q}) < (3'd2 + {2'b00, pop}));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD:  if (accept && k_q == LAST_IDX) state_d = S_START;
            S_START: state_d = S_WAIT;
            S_WAIT:  if (bus.fft_done) state_d = S_READ;
            S_READ:  if (last_pop) state_d = S_LOAD;
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_LOAD;
            k_q         <= '0;
            s_ready_q   <= 1'b0;
            fft_load_q  <= 1'b0;
            fft_start_q <= 1'b0;
            load_addr_q <= '0;
            din_q       <= '0;
            rd_ptr_q    <= '0;
            ret_q       <= 1'b0;
            ret_idx_q   <= '0;
            fifo_wp_q   <= 1'b0;
            fifo_rp_q   <= 1'b0;
            fifo_cnt_q  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_idx_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            s_ready_q   <= (state_d == S_LOAD);
            fft_load_q  <= accept;
            fft_start_q <= (state_q == S_START);

            if (accept) begin
                k_q         <= k_q + 1'b1;
                load_addr_q <= load_addr(k_q);
                din_q       <= {bus.s_data, {BIT_WIDTH{1'b0}}};
            end
            if (last_pop) k_q <= '0;

            if (state_q != S_READ) rd_ptr_q <= '0;
            else if (issue)        rd_ptr_q <= rd_ptr_q + 1'b1;
            ret_q     <= issue;
            ret_idx_q <= rd_ptr_q[N-1:0];

            if (push) begin
                fifo_data_q[fifo_wp_q] <= bus.dout;
                fifo_idx_q[fifo_wp_q]  <= ret_idx_q;
                fifo_wp_q              <= ~fifo_wp_q;
            end
            if (pop) fifo_rp_q <= ~fifo_rp_q;
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    assign bus.s_ready   = s_ready_q;
    assign bus.fft_load  = fft_load_q;
    assign bus.fft_start = fft_start_q;
    assign bus.add_rd    = (state_q == S_READ) ? rd_ptr_q[N-1:0] : load_addr_q;
    assign bus.din       = din_q;
    assign bus.m_valid   = m_valid;
    assign bus.m_data    = fifo_data_q[fifo_rp_q];
    assign bus.m_index   = fifo_idx_q[fifo_rp_q];
    assign bus.m_last    = m_valid && (fifo_idx_q[fifo_rp_q] == LAST_IDX);
    assign bus.busy      = (state_q != S_LOAD);
endmodule
